pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 41 ++++
 rtl/forward_unit.sv | 21 ++
 rtl/pipeline_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: divider FSM states,
// forward-select and result-select encodings, and the forwarding rule.
package pipeline_pkg;

    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } div_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    // Memory stage is the younger producer, so it wins over Writeback.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Execute-stage operand bypass select; purely combinational, zero latency,
// no flow control of its own.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard unit: forwarding, load-use stall, branch flush and a fixed-latency
// iterative-divider sequencer (1 init + DIV_CYCLES steps + 1 done) that freezes F/D/E.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       DivReqE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       DivInit,
    output logic       DivStep,
    output logic       DivBusy,
    output logic [4:0] DivCount
);

    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

    div_state_t state, state_nxt;
    logic [4:0] count_nxt;
    logic       div_start;
    logic       lw_stall;
    logic       div_stall;

    forward_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // A taken branch in Execute kills the divide before it starts.
    assign div_start = (state == S_IDLE) && DivReqE && !PCSrcE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            DivCount <= 5'd0;
        end else begin
            state    <= state_nxt;
            DivCount <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = DivCount;
        case (state)
            S_IDLE: begin
                if (div_start) begin
                    state_nxt = S_RUN;
                    count_nxt = DIV_LOAD;
                end
            end
            S_RUN: begin
                if (DivCount == 5'd0)
                    state_nxt = S_DONE;
                else
                    count_nxt = DivCount - 5'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        lw_stall  = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        div_stall = ((state == S_IDLE) && DivReqE) || (state == S_RUN);

        DivInit = div_start && !rst;
        DivStep = (state == S_RUN) && !rst;
        DivBusy = (state == S_RUN) && !rst;

        // The divider freeze outranks load-use, so no bubble enters Execute then.
        StallF = lw_stall || div_stall;
        StallD = lw_stall || div_stall;
        StallE = div_stall;
        FlushD = PCSrcE && !div_stall;
        FlushE = (lw_stall && !div_stall) || (PCSrcE && !div_stall);
        FlushM = div_stall;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios plus random traffic
// checked against a timeline model of the divider and rule-level hazard logic.
module tb_pipeline_ctrl;

    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, DivReqE, RegWriteM, RegWriteW;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       DivInit, DivStep, DivBusy;
    logic [4:0] DivCount;

    pipeline_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .DivReqE(DivReqE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .DivInit(DivInit), .DivStep(DivStep), .DivBusy(DivBusy), .DivCount(DivCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
        logic [1:0] fae, fbe;
        logic       init, step, busy;
        logic [4:0] count;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    // Divider timeline: -1 idle, 1..DC step cycles, DC+1 the done cycle.
    int   div_k  = -1;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic obs_t expect_now();
        obs_t e;
        bit idle, run, lw, ds;
        idle = (div_k < 0);
        run  = (div_k >= 1) && (div_k <= DC);
        lw   = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        ds   = (idle && DivReqE) || run;
        e.stall_f = lw || ds;
        e.stall_d = lw || ds;
        e.stall_e = ds;
        e.flush_d = PCSrcE && !ds;
        e.flush_e = (lw || PCSrcE) && !ds;
        e.flush_m = ds;
        e.fae     = fwd(Rs1E);
        e.fbe     = fwd(Rs2E);
        e.init    = idle && DivReqE && !PCSrcE && !rst;
        e.step    = run && !rst;
        e.busy    = run && !rst;
        e.count   = run ? 5'(DC - div_k) : 5'd0;
        return e;
    endfunction

    task automatic advance();
        if (rst)
            div_k = -1;
        else if (div_k < 0) begin
            if (DivReqE && !PCSrcE) div_k = 1;
        end else if (div_k == DC + 1)
            div_k = -1;
        else
            div_k = div_k + 1;
    endtask

    task automatic cyc(input logic r,
                       input logic [4:0] s1d, input logic [4:0] s2d,
                       input logic [4:0] s1e, input logic [4:0] s2e,
                       input logic [4:0] rde, input logic [1:0] rse,
                       input logic pc, input logic dr,
                       input logic [4:0] rdm, input logic wm,
                       input logic [4:0] rdw, input logic ww);
        @(posedge clk);
        advance();
        #1;
        rst = r; Rs1D = s1d; Rs2D = s2d; Rs1E = s1e; Rs2E = s2e; RdE = rde;
        ResultSrcE = rse; PCSrcE = pc; DivReqE = dr;
        RdM = rdm; RegWriteM = wm; RdW = rdw; RegWriteW = ww;
        if (rst) div_k = -1;
        exp_q.push_back(expect_now());
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
                      DivInit, DivStep, DivBusy, DivCount};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle%0d outputs got=%b required=%b (sF sD sE fD fE fM fA fB init step busy cnt)",
                             cycle, a, e);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0;
        PCSrcE = 0; DivReqE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;

        // reset state, including a divide request held during reset
        cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        idle_cyc(2);

        // forwarding priority and x0 exclusion
        cyc(0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 5, 1, 5, 1);
        cyc(0, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0, 1, 5, 1);
        cyc(0, 0, 0, 3, 3, 0, 2'b00, 0, 0, 3, 0, 3, 1);
        cyc(0, 0, 0, 4, 9, 0, 2'b00, 0, 0, 9, 1, 4, 1);

        // load-use hazard, then RdE = x0
        cyc(0, 0, 7, 0, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 7, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        cyc(0, 7, 0, 0, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0);

        // full divide with request held throughout
        for (int i = 0; i < DC + 2; i++)
            cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        idle_cyc(2);

        // taken branch with no divide
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        idle_cyc(1);

        // load-use and divide start together
        cyc(0, 0, 7, 0, 0, 7, 2'b01, 0, 1, 0, 0, 0, 0);
        idle_cyc(DC + 2);

        // reset mid-divide at count 10, then a fresh divide
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        idle_cyc(DC - 11);
        cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle_cyc(2);
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        idle_cyc(DC + 3);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
